// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe : three-stage (Issue / EX / WB) ALU datapath with register file,
// data memory, EX/WB operand forwarding and a one-cycle load-use stall.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready issue handshake (see below)
//   RegWrite, ALUsrc, ALUctrl, immOp, Resultsrc, MemWrite, rs1, rs2, rd
//                     decoded instruction fields, sampled on an accepted issue
//   ALUout, EQ        EX-stage ALU result and op1 == rs2-value compare (0 on bubble)
//   a0                architectural register x10
//   wb_valid, wb_rd, wb_data
//                     instruction retiring in WB this cycle (rd/data 0 when idle)
//
// Handshake: an instruction transfers into EX at a rising edge where
// in_valid & in_ready are both high. in_ready depends only on the EX stage
// and the presented rs1/rs2/ALUsrc/MemWrite, never on in_valid. While
// in_ready is low the producer holds its fields stable and a bubble enters EX.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEM_DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [2:0]               ALUctrl,
  input  logic [DATA_WIDTH-1:0]    immOp,
  input  logic                     Resultsrc,
  input  logic                     MemWrite,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    ALUout,
  output logic                     EQ,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     wb_valid,
  output logic [ADDRESS_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int MAW  = $clog2(MEM_DEPTH);
  localparam int NREG = 2 ** ADDRESS_WIDTH;

  // Register file and data memory
  logic [DATA_WIDTH-1:0] rf_q  [NREG];
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // EX stage registers
  logic                     ex_valid_q, ex_valid_d;
  logic                     ex_regwrite_q, ex_alusrc_q, ex_resultsrc_q, ex_memwrite_q;
  logic [2:0]               ex_aluctrl_q;
  logic [DATA_WIDTH-1:0]    ex_op1_q, ex_rs2v_q, ex_imm_q;
  logic [ADDRESS_WIDTH-1:0] ex_rd_q;

  // WB stage registers
  logic                     wb_valid_q, wb_regwrite_q, wb_resultsrc_q;
  logic [ADDRESS_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0]    wb_alu_q, wb_mem_q;

  // Issue-stage signals
  logic                     accept;
  logic                     stall;
  logic                     ex_fwd_ok, wb_fwd_ok, ex_load_rd;
  logic [DATA_WIDTH-1:0]    op1_d, rs2v_d;

  // EX-stage signals
  logic [DATA_WIDTH-1:0]    alu_op2, alu_raw, alu_res;
  logic [SHW-1:0]           shamt;
  logic [MAW-1:0]           mem_idx;

  // ---------------------------------------------------------------------------
  // Issue: hazard detection and operand resolution
  // ---------------------------------------------------------------------------
  // A load in EX cannot forward (its data only exists after the EX edge).
  assign ex_fwd_ok  = ex_valid_q & ex_regwrite_q & ~ex_resultsrc_q;
  assign wb_fwd_ok  = wb_valid_q & wb_regwrite_q;
  assign ex_load_rd = ex_valid_q & ex_regwrite_q & ex_resultsrc_q & (ex_rd_q != '0);

  // rs2 only matters when it feeds the ALU or provides store data.
  assign stall    = ex_load_rd &
                    ((ex_rd_q == rs1) | ((ex_rd_q == rs2) & (~ALUsrc | MemWrite)));
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  always_comb begin
    op1_d = rf_q[rs1];
    if (rs1 == '0)                               op1_d = '0;
    else if (ex_fwd_ok && (ex_rd_q == rs1))      op1_d = alu_res;
    else if (wb_fwd_ok && (wb_rd_q == rs1))      op1_d = wb_data;
  end

  always_comb begin
    rs2v_d = rf_q[rs2];
    if (rs2 == '0)                               rs2v_d = '0;
    else if (ex_fwd_ok && (ex_rd_q == rs2))      rs2v_d = alu_res;
    else if (wb_fwd_ok && (wb_rd_q == rs2))      rs2v_d = wb_data;
  end

  // ---------------------------------------------------------------------------
  // EX: ALU
  // ---------------------------------------------------------------------------
  assign alu_op2 = ex_alusrc_q ? ex_imm_q : ex_rs2v_q;
  assign shamt   = alu_op2[SHW-1:0];

  always_comb begin
    alu_raw = '0;
    case (ex_aluctrl_q)
      3'b000:  alu_raw = ex_op1_q + alu_op2;
      3'b001:  alu_raw = ex_op1_q - alu_op2;
      3'b010:  alu_raw = ex_op1_q & alu_op2;
      3'b011:  alu_raw = ex_op1_q | alu_op2;
      3'b100:  alu_raw = ex_op1_q ^ alu_op2;
      3'b101:  alu_raw = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_op1_q) < $signed(alu_op2))};
      3'b110:  alu_raw = ex_op1_q << shamt;
      3'b111:  alu_raw = ex_op1_q >> shamt;
      default: alu_raw = '0;
    endcase
  end

  assign alu_res = ex_valid_q ? alu_raw : '0;
  assign ALUout  = alu_res;
  assign EQ      = ex_valid_q & (ex_op1_q == ex_rs2v_q);

  // Word index; address bits above the memory size wrap around.
  assign mem_idx = alu_res[MAW+1:2];

  // ---------------------------------------------------------------------------
  // WB outputs
  // ---------------------------------------------------------------------------
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_valid_q ? wb_rd_q : '0;
  assign wb_data  = !wb_valid_q    ? '0       :
                    wb_resultsrc_q ? wb_mem_q : wb_alu_q;
  assign a0       = rf_q[ADDRESS_WIDTH'(10)];

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  assign ex_valid_d = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_resultsrc_q <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_aluctrl_q   <= '0;
      ex_op1_q       <= '0;
      ex_rs2v_q      <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept) begin
        ex_regwrite_q  <= RegWrite;
        ex_alusrc_q    <= ALUsrc;
        ex_resultsrc_q <= Resultsrc;
        ex_memwrite_q  <= MemWrite;
        ex_aluctrl_q   <= ALUctrl;
        ex_op1_q       <= op1_d;
        ex_rs2v_q      <= rs2v_d;
        ex_imm_q       <= immOp;
        ex_rd_q        <= rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_resultsrc_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_alu_q       <= '0;
      wb_mem_q       <= '0;
    end else begin
      wb_valid_q     <= ex_valid_q;
      wb_regwrite_q  <= ex_regwrite_q;
      wb_resultsrc_q <= ex_resultsrc_q;
      wb_rd_q        <= ex_rd_q;
      wb_alu_q       <= alu_res;
      // A store and a load are never in EX together, so the read port only
      // ever needs data written at an earlier edge: write-first falls out.
      wb_mem_q       <= mem_q[mem_idx];
    end
  end

  // Register file; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_valid_q && wb_regwrite_q && (wb_rd_q != '0)) begin
      rf_q[wb_rd_q] <= wb_data;
    end
  end

  // Data memory is not reset. Reset clears ex_valid_q asynchronously, which
  // blocks any store on or after the reset edge.
  always_ff @(posedge clk) begin
    if (ex_valid_q && ex_memwrite_q) mem_q[mem_idx] <= ex_rs2v_q;
  end

endmodule
